stone_renderer: RTL and testbench
=================================

Name: stone_renderer

Overview:
- Downstream of the rope controller; shares its 16-entry stone RAM read port.
- Once per frame, walks stone records 0..quantity-1, erases each stone's previously drawn square if it moved or vanished, then plots visible stones as 16x16 solid squares to the VGA adapter.
- Holds draw_stone_flag high for the whole pass, which stalls the rope FSM and hands it the RAM address mux.

Parameters:
- READ_LAT, 2: cycles from draw_index change to valid stone_data.
- SPRITE, 16: square edge in pixels; must be a power of two.
- COLOUR_W, 3: colour width.
- COL_BG, 3'b000: erase colour.
- COL_STONE, 3'b111: type 00.
- COL_GOLD, 3'b110: type 01.
- COL_DIAMOND, 3'b011: type 10/11.
- COL_GRAB, 3'b100: highlight colour (optional feature only).

Ports:
- clock  in  1  system clock
- resetn  in  1  synchronous active-low reset
- frame_start  in  1  one-cycle pulse requesting a render pass
- quantity  in  4  number of live records
- stone_data  in  32  RAM q; X=[31:23], Y=[18:11], type=[3:2], visible=[1], grabbed=[0]
- draw_stone_flag  out  1  pass in progress; RAM address owned by this block
- draw_index  out  4  RAM read address
- plot  out  1  pixel write strobe
- plot_x  out  9  pixel X
- plot_y  out  8  pixel Y
- plot_colour  out  COLOUR_W  pixel colour
- done  out  1  one-cycle pulse at end of pass

Behaviour:
- Reset: synchronous on resetn=0 at posedge clock, active-low; clock is clock. All outputs 0; FSM to IDLE; all 16 shadow entries (valid, X, Y) cleared. Reset mid-pass aborts immediately: flag and plot low next cycle, no done pulse.
- States: IDLE, ADDR, WAIT, LATCH, ERASE, DRAW, NEXT, FINISH.
- IDLE: frame_start=1 -> ADDR; draw_stone_flag=1 and draw_index=0 from the next cycle. frame_start while not IDLE is ignored (not queued).
- quantity==0: ADDR goes straight to FINISH. No plots; shadows untouched.
- ADDR -> WAIT, held READ_LAT cycles -> LATCH, which captures X, Y, type, visible and grabbed into local registers.
- Erase: shadow[i].valid and (not visible or X/Y differs from shadow) -> ERASE. Emits SPRITE*SPRITE pixels in raster order (dx inner, dy outer), one per cycle, colour COL_BG, at the shadow position.
- Draw: visible -> DRAW. Emits SPRITE*SPRITE pixels at the new X/Y, colour chosen by type. Visible stones are always redrawn, even if unmoved.
- Shadow update (both cases): after the erase/draw for index i, shadow[i] = {visible, X, Y}.
- Clipping: any pixel with x>=320 or y>=240 gets plot=0. Its cycle is still consumed, so ERASE and DRAW always last exactly SPRITE*SPRITE cycles.
- Coordinate width: X+dx is computed 10 bits wide, Y+dy 9 bits wide, before the clip compare; no wrap-around.
- NEXT: draw_index==quantity-1 or draw_index==15 -> FINISH; else draw_index+1 -> ADDR.
- FINISH: draw_stone_flag=0 and done=1 for one cycle -> IDLE.
- Output timing: plot_x, plot_y and plot_colour are registered and valid whenever plot=1; plot=0 in all non-plotting states.
- Shadows for indices >= quantity are neither read nor erased.

Optional Feature:
- Macro: GRAB_HIGHLIGHT_EN.
- Defined: when grabbed=1, DRAW uses COL_GRAB for border pixels (dx or dy equal to 0 or SPRITE-1) and the type colour for the interior.
- Undefined: grabbed bit is ignored; the whole square uses the type colour.
- ERASE is identical in both builds.

Test Plan:
- Reset then one frame_start, quantity=1, record X=100 Y=50 type=01 visible -> exactly 256 plot pulses, all colour 3'b110, covering x 100..115 and y 50..65; one done pulse; draw_stone_flag low after done.
- Second frame with the record moved to X=106 -> 256 COL_BG plots at 100..115/50..65, followed by 256 gold plots at 106..121.
- Visible cleared on the next frame -> 256 COL_BG plots only; a third frame produces zero plots.
- Record X=310 Y=230 visible -> only 10x10=100 plot pulses, yet the pass length equals that of an unclipped stone.
- quantity=0 -> zero plots; done exactly 3 cycles after frame_start (ADDR, FINISH, done); frame_start pulsed mid-pass -> no extra pass.
- resetn low during DRAW -> plot and flag 0 next cycle, no done; then frame_start -> full redraw with no erase, since all shadows are invalid.
- GRAB_HIGHLIGHT_EN defined, grabbed=1 -> 60 COL_GRAB border pixels and 196 type-colour interior pixels.

Source files
------------

// File: rtl/stone_renderer.sv
// stone_renderer: once per frame, walks the stone records in the shared RAM,
// erases squares of stones that moved or vanished, and plots every visible
// stone as a SPRITE x SPRITE solid square to the VGA adapter.
//
// Optional build feature: define GRAB_HIGHLIGHT_EN to outline grabbed stones
// in COL_GRAB (border pixels) with the type colour inside.
module stone_renderer #(
  parameter int                READ_LAT    = 2,
  parameter int                SPRITE      = 16,
  parameter int                COLOUR_W    = 3,
  parameter logic [COLOUR_W-1:0] COL_BG      = 3'b000,
  parameter logic [COLOUR_W-1:0] COL_STONE   = 3'b111,
  parameter logic [COLOUR_W-1:0] COL_GOLD    = 3'b110,
  parameter logic [COLOUR_W-1:0] COL_DIAMOND = 3'b011,
  parameter logic [COLOUR_W-1:0] COL_GRAB    = 3'b100
) (
  input  logic                clock,
  input  logic                resetn,
  input  logic                frame_start,
  input  logic [3:0]          quantity,
  input  logic [31:0]         stone_data,
  output logic                draw_stone_flag,
  output logic [3:0]          draw_index,
  output logic                plot,
  output logic [8:0]          plot_x,
  output logic [7:0]          plot_y,
  output logic [COLOUR_W-1:0] plot_colour,
  output logic                done
);

  localparam int SW = $clog2(SPRITE);
  localparam int PW = 2 * SW;

  typedef enum logic [2:0] {
    IDLE, ADDR, WAIT, LATCH, ERASE, DRAW, NEXT, FINISH
  } state_t;

  state_t          state;
  logic [3:0]      wait_cnt;
  logic [PW-1:0]   pix_cnt;

  // latched record fields for the stone currently being processed
  logic [8:0]      lx;
  logic [7:0]      ly;
  logic [1:0]      ltype;
  logic            lvis;
`ifdef GRAB_HIGHLIGHT_EN
  logic            lgrab;
`endif

  // shadow of what is currently on screen for each record
  logic [15:0]     sh_v;
  logic [8:0]      sh_x [16];
  logic [7:0]      sh_y [16];

  // raw record fields straight from the RAM port
  logic [8:0]      rec_x;
  logic [7:0]      rec_y;
  logic [1:0]      rec_type;
  logic            rec_vis;
  logic            unused_bits;

  assign rec_x    = stone_data[31:23];
  assign rec_y    = stone_data[18:11];
  assign rec_type = stone_data[3:2];
  assign rec_vis  = stone_data[1];
`ifdef GRAB_HIGHLIGHT_EN
  assign unused_bits = ^{stone_data[22:19], stone_data[10:4]};
`else
  assign unused_bits = ^{stone_data[22:19], stone_data[10:4], stone_data[0]};
`endif

  logic [SW-1:0]       dx, dy;
  logic [8:0]          bx;
  logic [7:0]          by;
  logic [9:0]          px;
  logic [8:0]          py;
  logic                in_range;
  logic                last_pix;
  logic                need_erase;
  logic                last_rec;
  logic [COLOUR_W-1:0] type_col;
  logic [COLOUR_W-1:0] draw_col;

  // pixel address generation, clip test and colour selection
  always_comb begin
    dx       = pix_cnt[SW-1:0];
    dy       = pix_cnt[PW-1:SW];
    // ERASE paints at the old on-screen position, DRAW at the new one
    bx       = (state == ERASE) ? sh_x[draw_index] : lx;
    by       = (state == ERASE) ? sh_y[draw_index] : ly;
    // widened by one bit so a stone near the edge clips rather than wraps
    px       = {1'b0, bx} + 10'(dx);
    py       = {1'b0, by} + 9'(dy);
    in_range = (px < 10'd320) && (py < 9'd240);
    last_pix = &pix_cnt;
    need_erase = sh_v[draw_index] &&
                 (!rec_vis || (sh_x[draw_index] != rec_x) ||
                  (sh_y[draw_index] != rec_y));
    last_rec = (draw_index == quantity - 4'd1) || (draw_index == 4'd15);
    case (ltype)
      2'b00:   type_col = COL_STONE;
      2'b01:   type_col = COL_GOLD;
      default: type_col = COL_DIAMOND;
    endcase
    draw_col = type_col;
`ifdef GRAB_HIGHLIGHT_EN
    if (lgrab && ((dx == '0) || (&dx) || (dy == '0) || (&dy)))
      draw_col = COL_GRAB;
`endif
  end

  // render FSM with registered outputs and shadow table
  always_ff @(posedge clock) begin
    if (!resetn) begin
      state           <= IDLE;
      wait_cnt        <= '0;
      pix_cnt         <= '0;
      lx              <= '0;
      ly              <= '0;
      ltype           <= '0;
      lvis            <= 1'b0;
`ifdef GRAB_HIGHLIGHT_EN
      lgrab           <= 1'b0;
`endif
      draw_stone_flag <= 1'b0;
      draw_index      <= '0;
      plot            <= 1'b0;
      plot_x          <= '0;
      plot_y          <= '0;
      plot_colour     <= '0;
      done            <= 1'b0;
      sh_v            <= '0;
      for (int i = 0; i < 16; i++) begin
        sh_x[i] <= '0;
        sh_y[i] <= '0;
      end
    end else begin
      plot <= 1'b0;
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (frame_start) begin
            state           <= ADDR;
            draw_stone_flag <= 1'b1;
            draw_index      <= '0;
          end
        end
        ADDR: begin
          wait_cnt <= '0;
          state    <= (quantity == 4'd0) ? FINISH : WAIT;
        end
        WAIT: begin
          if (wait_cnt == 4'(READ_LAT - 1)) state <= LATCH;
          else wait_cnt <= wait_cnt + 4'd1;
        end
        LATCH: begin
          lx      <= rec_x;
          ly      <= rec_y;
          ltype   <= rec_type;
          lvis    <= rec_vis;
`ifdef GRAB_HIGHLIGHT_EN
          lgrab   <= stone_data[0];
`endif
          pix_cnt <= '0;
          if (need_erase)   state <= ERASE;
          else if (rec_vis) state <= DRAW;
          else              state <= NEXT;
        end
        ERASE: begin
          plot        <= in_range;
          plot_x      <= px[8:0];
          plot_y      <= py[7:0];
          plot_colour <= COL_BG;
          pix_cnt     <= pix_cnt + 1'b1;
          if (last_pix) state <= lvis ? DRAW : NEXT;
        end
        DRAW: begin
          plot        <= in_range;
          plot_x      <= px[8:0];
          plot_y      <= py[7:0];
          plot_colour <= draw_col;
          pix_cnt     <= pix_cnt + 1'b1;
          if (last_pix) state <= NEXT;
        end
        NEXT: begin
          // record what is now on screen for this index
          sh_v[draw_index] <= lvis;
          sh_x[draw_index] <= lx;
          sh_y[draw_index] <= ly;
          if (last_rec) state <= FINISH;
          else begin
            draw_index <= draw_index + 4'd1;
            state      <= ADDR;
          end
        end
        FINISH: begin
          draw_stone_flag <= 1'b0;
          done            <= 1'b1;
          state           <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_stone_renderer.sv
// Self-checking bench for stone_renderer: RAM model with 2-cycle read latency,
// plus a frame-level reference that lists the expected pixel stream.
module tb_stone_renderer;

  logic        clock = 1'b0;
  logic        resetn;
  logic        frame_start;
  logic [3:0]  quantity;
  logic [31:0] stone_data;
  logic        draw_stone_flag;
  logic [3:0]  draw_index;
  logic        plot;
  logic [8:0]  plot_x;
  logic [7:0]  plot_y;
  logic [2:0]  plot_colour;
  logic        done;

  stone_renderer dut (
    .clock(clock), .resetn(resetn), .frame_start(frame_start),
    .quantity(quantity), .stone_data(stone_data),
    .draw_stone_flag(draw_stone_flag), .draw_index(draw_index),
    .plot(plot), .plot_x(plot_x), .plot_y(plot_y),
    .plot_colour(plot_colour), .done(done)
  );

  always #5 clock = ~clock;

  // stone RAM: two register stages between address and q
  logic [31:0] mem [16];
  logic [31:0] r1, rq;
  always @(posedge clock) begin
    r1 <= mem[draw_index];
    rq <= r1;
  end
  assign stone_data = rq;

  int tests = 0;
  int fails = 0;

  // reference shadows and expected pixel stream
  bit          m_v [16];
  int          m_x [16];
  int          m_y [16];
  logic [19:0] expq [$];

  int last_len, last_plots, last_grab;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] rec(input int x, input int y, input int t,
                                      input bit vis, input bit grab);
    logic [31:0] r;
    r = $urandom;                    // junk in the unused bits
    r[31:23] = 9'(x);
    r[18:11] = 8'(y);
    r[3:2]   = 2'(t);
    r[1]     = vis;
    r[0]     = grab;
    return r;
  endfunction

  function automatic logic [2:0] colour_of(input int t, input bit grab,
                                           input int dx, input int dy);
    logic [2:0] c;
    c = (t == 0) ? 3'b111 : (t == 1) ? 3'b110 : 3'b011;
`ifdef GRAB_HIGHLIGHT_EN
    if (grab && (dx == 0 || dx == 15 || dy == 0 || dy == 15)) c = 3'b100;
`endif
    return c;
  endfunction

  task automatic push_square(input int x, input int y, input bit erase,
                             input int t, input bit grab);
    for (int dy = 0; dy < 16; dy++)
      for (int dx = 0; dx < 16; dx++)
        if (x + dx < 320 && y + dy < 240)
          expq.push_back({9'(x + dx), 8'(y + dy),
                          erase ? 3'b000 : colour_of(t, grab, dx, dy)});
  endtask

  task automatic build_exp(input int q);
    expq.delete();
    for (int i = 0; i < q && i < 16; i++) begin
      int x, y, t; bit v, g;
      x = int'(mem[i][31:23]); y = int'(mem[i][18:11]);
      t = int'(mem[i][3:2]);   v = mem[i][1]; g = mem[i][0];
      if (m_v[i] && (!v || x != m_x[i] || y != m_y[i]))
        push_square(m_x[i], m_y[i], 1'b1, 0, 1'b0);
      if (v) push_square(x, y, 1'b0, t, g);
      m_v[i] = v; m_x[i] = x; m_y[i] = y;
    end
  endtask

  task automatic clear_model();
    for (int i = 0; i < 16; i++) begin m_v[i] = 0; m_x[i] = 0; m_y[i] = 0; end
  endtask

  // one render pass; optionally pulses frame_start again mid-pass
  task automatic run_frame(input int q, input bit mid);
    int n, bad, flagdrop, extra;
    logic [19:0] e;
    quantity = 4'(q);
    build_exp(q);
    last_plots = 0; last_grab = 0; bad = 0; flagdrop = 0;
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    n = 1;
    while (done !== 1'b1 && n < 20000) begin
      if (draw_stone_flag !== 1'b1) flagdrop++;
      if (plot === 1'b1) begin
        last_plots++;
        if (plot_colour === 3'b100) last_grab++;
        if (expq.size() == 0) bad++;
        else begin
          e = expq.pop_front();
          if (e !== {plot_x, plot_y, plot_colour}) bad++;
        end
      end
      frame_start = mid && (n == 40);
      tick();
      n++;
    end
    frame_start = 1'b0;
    last_len = n;
    chk("done_seen", 32'(done), 1);
    chk("flag_low_at_done", 32'(draw_stone_flag), 0);
    chk("flag_held_in_pass", flagdrop, 0);
    chk("pixel_mismatches", bad, 0);
    chk("pixels_missing", expq.size(), 0);
    extra = 0;
    repeat (30) begin
      tick();
      if (plot !== 1'b0 || done !== 1'b0 || draw_stone_flag !== 1'b0) extra++;
    end
    chk("idle_after_pass", extra, 0);
  endtask

  int l_unclipped, cnt, n;

  initial begin
    resetn = 1'b0; frame_start = 1'b0; quantity = '0;
    for (int i = 0; i < 16; i++) mem[i] = '0;
    clear_model();
    tick(); tick();
    chk("rst_flag", 32'(draw_stone_flag), 0);
    chk("rst_plot", 32'(plot), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_index", 32'(draw_index), 0);
    chk("rst_xyc", {plot_x, plot_y, plot_colour}, 0);
    resetn = 1'b1;
    tick();

    // single gold stone, first draw
    mem[0] = rec(100, 50, 1, 1, 0);
    run_frame(1, 0);
    chk("first_draw_plots", last_plots, 256);
    l_unclipped = last_len;

    // moved: erase then redraw; stray frame_start mid-pass
    mem[0] = rec(106, 50, 1, 1, 0);
    run_frame(1, 1);
    chk("move_plots", last_plots, 512);

    // vanished: erase only, then nothing
    mem[0] = rec(106, 50, 1, 0, 0);
    run_frame(1, 0);
    chk("vanish_plots", last_plots, 256);
    run_frame(1, 0);
    chk("empty_plots", last_plots, 0);

    // clipped at bottom-right corner
    mem[0] = rec(310, 230, 0, 1, 0);
    run_frame(1, 0);
    chk("clip_plots", last_plots, 100);
    chk("clip_pass_len", last_len, l_unclipped);

    // nothing to render
    run_frame(0, 0);
    chk("q0_plots", last_plots, 0);
    chk("q0_done_latency", last_len, 3);

    // grabbed diamond: erase corner stone, then outlined draw
    mem[0] = rec(20, 20, 2, 1, 1);
    run_frame(1, 0);
    chk("grab_total", last_plots, 356);
`ifdef GRAB_HIGHLIGHT_EN
    chk("grab_border", last_grab, 60);
`else
    chk("grab_border", last_grab, 0);
`endif

    // randomized multi-stone frames
    for (int f = 0; f < 6; f++) begin
      for (int i = 0; i < 16; i++)
        if ($urandom_range(1, 0) == 1)
          mem[i] = rec($urandom_range(319, 0), $urandom_range(239, 0),
                       $urandom_range(3, 0), $urandom_range(3, 0) != 0,
                       $urandom_range(1, 0) == 1);
      run_frame($urandom_range(16, 1), f[0]);
    end

    // reset in the middle of DRAW
    quantity = 4'd1;
    mem[0] = rec(50, 60, 1, 1, 0);
    frame_start = 1'b1; tick(); frame_start = 1'b0;
    n = 0;
    while (!(plot === 1'b1 && plot_colour === 3'b110) && n < 2000) begin tick(); n++; end
    chk("draw_reached", 32'(n < 2000), 1);
    repeat (20) tick();
    resetn = 1'b0;
    tick();
    chk("abort_plot", 32'(plot), 0);
    chk("abort_flag", 32'(draw_stone_flag), 0);
    chk("abort_done", 32'(done), 0);
    resetn = 1'b1;
    clear_model();
    cnt = 0;
    repeat (400) begin
      tick();
      if (done !== 1'b0 || plot !== 1'b0) cnt++;
    end
    chk("abort_quiet", cnt, 0);
    run_frame(1, 0);
    chk("redraw_no_erase", last_plots, 256);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
